// File: rtl/vfu_axi64_rd_arbiter.sv
// vfu_axi64_rd_arbiter
//   Shares the VFU's single 64-bit AXI read port between two requesters
//   (0 = vector load unit, 1 = vector gather/prefetch unit).
//   AR: round-robin grant into one registered AR stage toward memory.
//   R : beats routed combinationally to the owner selected by rid[ID_W].
//   Per-requester outstanding-burst counters cap traffic at MAX_OUTSTANDING.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_ar*[i]               requester i AR channel (valid/ready/addr/len/size/burst/cache/id)
//   s_r*[i]                requester i R channel (valid/ready/data/resp/last/id)
//   m_axi_ar*              registered AR toward memory, arid = {owner, requester id}
//   m_axi_r*               R channel from memory; m_axi_rready follows the owner
module vfu_axi64_rd_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           s_arvalid,
  output logic [1:0]           s_arready,
  input  logic [1:0][31:0]     s_araddr,
  input  logic [1:0][7:0]      s_arlen,
  input  logic [1:0][2:0]      s_arsize,
  input  logic [1:0][1:0]      s_arburst,
  input  logic [1:0][3:0]      s_arcache,
  input  logic [1:0][ID_W-1:0] s_arid,
  output logic [1:0]           s_rvalid,
  input  logic [1:0]           s_rready,
  output logic [1:0][63:0]     s_rdata,
  output logic [1:0][1:0]      s_rresp,
  output logic [1:0]           s_rlast,
  output logic [1:0][ID_W-1:0] s_rid,
  output logic                 m_axi_arvalid,
  output logic [31:0]          m_axi_araddr,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic [3:0]           m_axi_arcache,
  output logic [ID_W:0]        m_axi_arid,
  input  logic                 m_axi_arready,
  input  logic                 m_axi_rvalid,
  input  logic [63:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic [ID_W:0]        m_axi_rid,
  output logic                 m_axi_rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          cache_q, cache_d;
  logic [ID_W:0]       id_q, id_d;

  logic [1:0] elig;
  logic       can_load, load, grant, owner, r_last_hs;

  // AR arbitration and register load
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = s_arvalid[i] && (cnt_q[i] < MAX_C);
    end
    // Held low during reset so nothing is handshaken while state is clearing.
    can_load  = rst_n && ((state_q == EMPTY) || m_axi_arready);
    load      = can_load && (|elig);
    grant     = (&elig) ? rr_ptr_q : elig[1];
    s_arready = load ? (grant ? 2'b10 : 2'b01) : 2'b00;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    cache_d  = cache_q;
    id_d     = id_q;
    if (load) begin
      state_d  = FULL;
      rr_ptr_d = ~grant;
      addr_d   = s_araddr[grant];
      len_d    = s_arlen[grant];
      size_d   = s_arsize[grant];
      burst_d  = s_arburst[grant];
      cache_d  = s_arcache[grant];
      id_d     = {grant, s_arid[grant]};
    end else if ((state_q == FULL) && m_axi_arready) begin
      state_d = EMPTY;
    end
  end

  // R routing by the owner bit of rid
  always_comb begin
    owner         = m_axi_rid[ID_W];
    s_rvalid      = owner ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid};
    m_axi_rready  = s_rready[owner];
    s_rdata       = {m_axi_rdata, m_axi_rdata};
    s_rresp       = {m_axi_rresp, m_axi_rresp};
    s_rlast       = {m_axi_rlast, m_axi_rlast};
    s_rid         = {m_axi_rid[ID_W-1:0], m_axi_rid[ID_W-1:0]};
    r_last_hs     = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  end

  // Outstanding counters; decrement floors at zero for stray beats after reset.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      logic inc, dec;
      inc = s_arvalid[i] && s_arready[i];
      dec = r_last_hs && (owner == i[0]) && (cnt_q[i] != '0);
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cache_q  <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      cache_q  <= cache_d;
      id_q     <= id_d;
    end
  end

  assign m_axi_arvalid = (state_q == FULL);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;
  assign m_axi_arcache = cache_q;
  assign m_axi_arid    = id_q;

  // A last beat for a requester with nothing outstanding is a protocol error.
  rlast_without_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    r_last_hs |-> (cnt_q[owner] != '0));

endmodule

// File: tb/tb_vfu_axi64_rd_arbiter.sv
// Directed testbench for vfu_axi64_rd_arbiter: single request, contention,
// outstanding limit, R routing, AR backpressure and asynchronous reset.
module tb_vfu_axi64_rd_arbiter;

  localparam int ID_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           s_arvalid = '0;
  logic [1:0]           s_arready;
  logic [1:0][31:0]     s_araddr = '0;
  logic [1:0][7:0]      s_arlen = '0;
  logic [1:0][2:0]      s_arsize = '0;
  logic [1:0][1:0]      s_arburst = '0;
  logic [1:0][3:0]      s_arcache = '0;
  logic [1:0][ID_W-1:0] s_arid = '0;
  logic [1:0]           s_rvalid;
  logic [1:0]           s_rready = '0;
  logic [1:0][63:0]     s_rdata;
  logic [1:0][1:0]      s_rresp;
  logic [1:0]           s_rlast;
  logic [1:0][ID_W-1:0] s_rid;
  logic                 m_axi_arvalid;
  logic [31:0]          m_axi_araddr;
  logic [7:0]           m_axi_arlen;
  logic [2:0]           m_axi_arsize;
  logic [1:0]           m_axi_arburst;
  logic [3:0]           m_axi_arcache;
  logic [ID_W:0]        m_axi_arid;
  logic                 m_axi_arready = 1'b0;
  logic                 m_axi_rvalid = 1'b0;
  logic [63:0]          m_axi_rdata = '0;
  logic [1:0]           m_axi_rresp = '0;
  logic                 m_axi_rlast = 1'b0;
  logic [ID_W:0]        m_axi_rid = '0;
  logic                 m_axi_rready;

  int tests = 0;
  int fails = 0;

  vfu_axi64_rd_arbiter #(.MAX_OUTSTANDING(4), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arcache(s_arcache), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arid(m_axi_arid), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rid(m_axi_rid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] pat;
    int beat;

    // Reset state (requests driven to confirm s_arready is held low)
    s_arvalid = 2'b11;
    #1;
    chk("rst_arready", 64'(s_arready), 64'h0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'h0);
    step();
    chk("rst_araddr", 64'(m_axi_araddr), 64'h0);
    chk("rst_arid", 64'(m_axi_arid), 64'h0);
    s_arvalid = 2'b00;
    rst_n = 1'b1;
    step();

    // 1. Single request
    s_arvalid   = 2'b01;
    s_araddr[0] = 32'h8000_0100;
    s_arlen[0]  = 8'd3;
    s_arsize[0] = 3'd3;
    s_arburst[0] = 2'd1;
    s_arcache[0] = 4'h3;
    s_arid[0]   = 5'd5;
    #1;
    chk("t1_arready", 64'(s_arready), 64'h1);
    step();
    s_arvalid = 2'b00;
    chk("t1_arvalid", 64'(m_axi_arvalid), 64'h1);
    chk("t1_arid", 64'(m_axi_arid), 64'h05);
    chk("t1_araddr", 64'(m_axi_araddr), 64'h8000_0100);
    chk("t1_arlen", 64'(m_axi_arlen), 64'h3);
    chk("t1_arcache", 64'(m_axi_arcache), 64'h3);
    m_axi_arready = 1'b1;
    step();
    chk("t1_drain", 64'(m_axi_arvalid), 64'h0);

    // 2. Contention: grants 0,1,0,1 from a freshly reset pointer
    do_reset();
    s_arid[0] = 5'd1;
    s_arid[1] = 5'd2;
    s_araddr[1] = 32'h4000_0000;
    s_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant", 64'(s_arready), (k % 2 == 0) ? 64'h1 : 64'h2);
      step();
      chk("t2_arid", 64'(m_axi_arid), (k % 2 == 0) ? 64'h01 : 64'h22);
    end
    s_arvalid = 2'b00;
    step();

    // 3. Outstanding limit on requester 0
    do_reset();
    s_arvalid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_accept", 64'(s_arready), 64'h1);
      step();
    end
    #1;
    chk("t3_limit", 64'(s_arready), 64'h0);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    m_axi_rid    = 6'h01;
    s_rready     = 2'b01;
    #1;
    chk("t3_rvalid", 64'(s_rvalid), 64'h1);
    chk("t3_rready", 64'(m_axi_rready), 64'h1);
    chk("t3_limit_same_cycle", 64'(s_arready), 64'h0);
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    s_rready     = 2'b00;
    #1;
    chk("t3_reaccept", 64'(s_arready), 64'h1);
    step();
    s_arvalid = 2'b00;

    // 4. R routing to requester 1 with s_rready toggling
    do_reset();
    s_arvalid = 2'b10;
    s_arid[1] = 5'd3;
    #1;
    chk("t4_ar_grant", 64'(s_arready), 64'h2);
    step();
    chk("t4_ar_id", 64'(m_axi_arid), 64'h23);
    for (int k = 0; k < 3; k++) step();
    #1;
    chk("t4_limit", 64'(s_arready), 64'h0);
    pat  = 6'b110101;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 6'h23;
      m_axi_rdata  = 64'hA5A5_0000_0000_0000 | 64'(beat);
      m_axi_rresp  = (beat == 2) ? 2'd2 : 2'd0;
      m_axi_rlast  = (beat == 3);
      s_rready     = {pat[c], 1'b1};
      #1;
      chk("t4_rvalid", 64'(s_rvalid), 64'h2);
      chk("t4_rready", 64'(m_axi_rready), 64'(pat[c]));
      chk("t4_rid", 64'(s_rid[1]), 64'h3);
      chk("t4_rdata", s_rdata[1], 64'hA5A5_0000_0000_0000 | 64'(beat));
      chk("t4_rresp", 64'(s_rresp[1]), (beat == 2) ? 64'h2 : 64'h0);
      chk("t4_no_early_dec", 64'(s_arready), 64'h0);
      step();
      if (pat[c]) beat++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'd0;
    s_rready     = 2'b00;
    #1;
    chk("t4_dec_on_last", 64'(s_arready), 64'h2);
    step();
    s_arvalid = 2'b00;

    // 5. AR backpressure
    do_reset();
    m_axi_arready = 1'b0;
    s_arvalid   = 2'b01;
    s_araddr[0] = 32'h1234_5678;
    s_arid[0]   = 5'd7;
    s_araddr[1] = 32'h9ABC_DEF0;
    s_arid[1]   = 5'd9;
    step();
    s_arvalid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_arready", 64'(s_arready), 64'h0);
      chk("t5_arvalid", 64'(m_axi_arvalid), 64'h1);
      chk("t5_araddr", 64'(m_axi_araddr), 64'h1234_5678);
      chk("t5_arid", 64'(m_axi_arid), 64'h07);
      step();
    end
    m_axi_arready = 1'b1;
    #1;
    chk("t5_release_grant", 64'(s_arready), 64'h2);
    step();
    s_arvalid = 2'b00;
    chk("t5_next_addr", 64'(m_axi_araddr), 64'h9ABC_DEF0);
    chk("t5_next_id", 64'(m_axi_arid), 64'h29);
    step();
    chk("t5_empty", 64'(m_axi_arvalid), 64'h0);

    // 6. Asynchronous reset with requester 0 holding two bursts
    do_reset();
    m_axi_arready = 1'b1;
    s_arvalid = 2'b01;
    step();
    step();
    s_arvalid = 2'b00;
    m_axi_arready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arvalid_async", 64'(m_axi_arvalid), 64'h0);
    chk("t6_araddr_async", 64'(m_axi_araddr), 64'h0);
    s_arvalid = 2'b01;
    #1;
    chk("t6_arready_in_rst", 64'(s_arready), 64'h0);
    step();
    rst_n = 1'b1;
    m_axi_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_cnt_cleared", 64'(s_arready), 64'h1);
      step();
    end
    #1;
    chk("t6_limit", 64'(s_arready), 64'h0);
    s_arvalid = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
